key_debounce_array: RTL and testbench
=====================================

// Module: key_debounce_array
// PURPOSE
//  Multi-channel key debouncer with press/release/long-press/auto-repeat event pulses.
//  Parametrised successor to the single-key filter: N independent channels, selectable
//  key polarity, long-press detection and optional auto-repeat while a key is held.
//  Sits between the board push-buttons and the clock/setting control FSMs; all outputs are sys_clk-synchronous.
// PARAMETERS
//  N_KEYS        4         number of independent key channels
//  CNT_W         26        width of per-channel debounce and hold counters
//  DEBOUNCE_CYC  1000000   stable cycles required to accept a press or release (20 ms @ 50 MHz)
//  LONG_CYC      50000000  held cycles after accepted press until long-press event (1 s)
//  REPEAT_CYC    10000000  period of repeat events after long-press, when enabled (200 ms)
//  ACTIVE_LOW    1         1: raw key reads 0 when pressed; 0: raw key reads 1 when pressed
// PORTS
//  sys_clk        in   1       system clock
//  rst_n          in   1       asynchronous active-low reset
//  key            in   N_KEYS  raw, unsynchronised key inputs
//  repeat_en      in   1       1: generate repeat pulses after long-press (sampled each cycle)
//  key_level      out  N_KEYS  debounced level, 1 = pressed (polarity-normalised)
//  key_p_flag     out  N_KEYS  1-cycle pulse: press accepted
//  key_r_flag     out  N_KEYS  1-cycle pulse: release accepted
//  key_long_flag  out  N_KEYS  1-cycle pulse: key held LONG_CYC cycles after press
//  key_rep_flag   out  N_KEYS  1-cycle pulse: auto-repeat tick
// BEHAVIOUR
//  Reset: all outputs 0; FSMs IDLE; counters 0; 2-FF synchronisers load the RELEASED level
//   (no false press out of reset). Key held through reset -> normal press detected after debounce.
//  Per channel: 2-FF sync -> ks (1 = pressed after polarity normalisation). Channels fully independent.
//  FSM states: IDLE, P_FILTER, HELD, R_FILTER.
//   IDLE:     ks=1 -> P_FILTER, dcnt=0.
//   P_FILTER: ks=0 -> IDLE (bounce rejected, no flag). ks=1 & dcnt==DEBOUNCE_CYC-1 -> HELD,
//             key_p_flag pulse, hcnt=0. Else dcnt++.
//   HELD:     ks=0 -> R_FILTER, dcnt=0. Else hcnt advances (see hold rules).
//   R_FILTER: ks=1 -> HELD (glitch rejected, hcnt kept, frozen while in R_FILTER).
//             ks=0 & dcnt==DEBOUNCE_CYC-1 -> IDLE, key_r_flag pulse. Else dcnt++.
//  key_level = 1 in HELD and R_FILTER, 0 in IDLE and P_FILTER (registered).
//  Latency: key_p_flag / key_level rise exactly DEBOUNCE_CYC+3 cycles after the first raw edge of a
//   clean press; key_r_flag / key_level fall the same after a clean release.
//  Hold rules (HELD only): hcnt==LONG_CYC-1 -> key_long_flag pulse, hcnt=0, phase=REPEAT.
//   phase REPEAT & repeat_en=1: every REPEAT_CYC cycles -> key_rep_flag pulse.
//   phase REPEAT & repeat_en=0: hcnt holds at 0, no pulses; re-enabling restarts a full REPEAT_CYC period.
//   key_long_flag at most once per press; phase cleared on entry to IDLE.
//  Flags: each exactly 1 cycle; at most one of p/r/long/rep per channel per cycle; multiple
//   channels may pulse in the same cycle.
//  Width: DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC each >=2 and <2^CNT_W; counters never wrap.
//  Reset mid-operation: immediate return to reset state; no r_flag is emitted for the aborted press.
// TESTING (bench params: N_KEYS=2, DEBOUNCE_CYC=10, LONG_CYC=40, REPEAT_CYC=15, ACTIVE_LOW=1)
//  1 Reset, key=2'b11 for 100 cycles -> all outputs 0 throughout, no flag ever.
//  2 key[0] bounces low 5 cyc/high 3 cyc x3 then stays low -> exactly one key_p_flag[0], 13 cycles
//    after final falling edge; key_level[0]=1 same cycle+1; key[1] outputs stay 0.
//  3 key[0] held low 100 cycles, repeat_en=0 -> p_flag, long_flag 40 cycles later, no rep_flag;
//    release -> r_flag 13 cycles after rising edge.
//  4 Same with repeat_en=1 -> rep_flag at long+15, +30, +45 ...; drop repeat_en -> pulses stop.
//  5 During HELD, key[0] high for 4 cycles -> no r_flag, key_level stays 1, long_flag timing shifted by 4.
//  6 Both keys pressed same cycle -> p_flag 2'b11 same cycle; rst_n low mid-hold -> all outputs 0 at once,
//    no r_flag after reset release while keys stay released.

Source files
------------

// File: rtl/key_debounce_array.sv
// Multi-channel key debouncer: per-channel 2-FF sync, press/release filter FSM,
// long-press detection and optional auto-repeat, all as 1-cycle sys_clk pulses.
module key_debounce_ch #(
  parameter int CNT_W        = 26,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_raw,
  input  logic repeat_en,
  output logic level,
  output logic p_flag,
  output logic r_flag,
  output logic long_flag,
  output logic rep_flag
);
  typedef enum logic [1:0] {IDLE, P_FILTER, HELD, R_FILTER} state_t;

  localparam logic             INV       = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  state_t           state;
  logic [1:0]       sync;
  logic             ks;
  logic [CNT_W-1:0] dcnt, hcnt, hcnt_nx;
  logic             rep_phase, phase_nx, long_hit, rep_hit;

  // Polarity is normalised before the synchroniser so reset loads "released".
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], key_raw ^ INV};
  end
  assign ks = sync[1];

  // One hold-counter step, applied on every cycle the accepted key reads pressed.
  always_comb begin
    hcnt_nx  = hcnt + CNT_W'(1);
    phase_nx = rep_phase;
    long_hit = 1'b0;
    rep_hit  = 1'b0;
    if (!rep_phase) begin
      if (hcnt == LONG_LAST) begin
        hcnt_nx  = '0;
        phase_nx = 1'b1;
        long_hit = 1'b1;
      end
    end else if (!repeat_en) begin
      hcnt_nx = '0;
    end else if (hcnt == REP_LAST) begin
      hcnt_nx = '0;
      rep_hit = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dcnt      <= '0;
      hcnt      <= '0;
      rep_phase <= 1'b0;
      level     <= 1'b0;
      p_flag    <= 1'b0;
      r_flag    <= 1'b0;
      long_flag <= 1'b0;
      rep_flag  <= 1'b0;
    end else begin
      p_flag    <= 1'b0;
      r_flag    <= 1'b0;
      long_flag <= 1'b0;
      rep_flag  <= 1'b0;
      case (state)
        IDLE: if (ks) begin
          state <= P_FILTER;
          dcnt  <= '0;
        end
        P_FILTER: begin
          if (!ks) state <= IDLE;
          else if (dcnt == DB_LAST) begin
            state     <= HELD;
            level     <= 1'b1;
            p_flag    <= 1'b1;
            hcnt      <= '0;
            rep_phase <= 1'b0;
          end else dcnt <= dcnt + CNT_W'(1);
        end
        HELD: begin
          if (!ks) begin
            state <= R_FILTER;
            dcnt  <= '0;
          end else begin
            hcnt      <= hcnt_nx;
            rep_phase <= phase_nx;
            long_flag <= long_hit;
            rep_flag  <= rep_hit;
          end
        end
        R_FILTER: begin
          // Glitch rejected: the returning cycle already counts as held time.
          if (ks) begin
            state     <= HELD;
            hcnt      <= hcnt_nx;
            rep_phase <= phase_nx;
            long_flag <= long_hit;
            rep_flag  <= rep_hit;
          end else if (dcnt == DB_LAST) begin
            state     <= IDLE;
            level     <= 1'b0;
            r_flag    <= 1'b1;
            rep_phase <= 1'b0;
          end else dcnt <= dcnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module key_debounce_array #(
  parameter int N_KEYS       = 4,
  parameter int CNT_W        = 26,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  input  logic              repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_p_flag,
  output logic [N_KEYS-1:0] key_r_flag,
  output logic [N_KEYS-1:0] key_long_flag,
  output logic [N_KEYS-1:0] key_rep_flag
);
  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .CNT_W(CNT_W), .DEBOUNCE_CYC(DEBOUNCE_CYC), .LONG_CYC(LONG_CYC),
      .REPEAT_CYC(REPEAT_CYC), .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .key_raw  (key[g]),
      .repeat_en(repeat_en),
      .level    (key_level[g]),
      .p_flag   (key_p_flag[g]),
      .r_flag   (key_r_flag[g]),
      .long_flag(key_long_flag[g]),
      .rep_flag (key_rep_flag[g])
    );
  end
endmodule

// File: tb/tb_key_debounce_array.sv
// Scoreboard bench: expected flag events (cycle, channel, kind) are queued as
// stimulus is driven and matched against every flag pulse the DUT produces.
module tb_key_debounce_array;
  localparam int NK = 2;
  localparam int KP = 0, KR = 1, KL = 2, KRP = 3;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;
  logic          repeat_en;
  logic [NK-1:0] key_level, key_p_flag, key_r_flag, key_long_flag, key_rep_flag;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_q[$];
  int   base;
  logic [3:0] flags;
  int   e;

  key_debounce_array #(
    .N_KEYS(NK), .CNT_W(8), .DEBOUNCE_CYC(10), .LONG_CYC(40),
    .REPEAT_CYC(15), .ACTIVE_LOW(1)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .key          (key),
    .repeat_en    (repeat_en),
    .key_level    (key_level),
    .key_p_flag   (key_p_flag),
    .key_r_flag   (key_r_flag),
    .key_long_flag(key_long_flag),
    .key_rep_flag (key_rep_flag)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int enc(int t, int ch, int k);
    return t * 16 + ch * 4 + k;
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push(input int dly, input int ch, input int k);
    exp_q.push_back(enc(cyc + dly, ch, k));
  endtask

  // Every flag pulse must match the head of the scoreboard.
  always @(posedge sys_clk) begin
    #1;
    cyc++;
    for (int ch = 0; ch < NK; ch++) begin
      flags = {key_rep_flag[ch], key_long_flag[ch], key_r_flag[ch], key_p_flag[ch]};
      for (int k = 0; k < 4; k++) begin
        if (flags[k]) begin
          if (exp_q.size() == 0) chk("evt_unexpected", enc(cyc, ch, k), -1);
          else begin
            e = exp_q.pop_front();
            chk("evt", enc(cyc, ch, k), e);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; key = 2'b11; repeat_en = 1'b0;
    tick(3);
    chk("reset_outs", int'({key_level, key_p_flag, key_r_flag, key_long_flag, key_rep_flag}), 0);
    rst_n = 1'b1;
    tick(100);
    chk("idle_outs", int'({key_level, key_p_flag, key_r_flag, key_long_flag, key_rep_flag}), 0);

    // Bounce then clean press, held 100 cycles without repeat.
    for (int i = 0; i < 3; i++) begin
      key[0] = 1'b0; tick(5);
      key[0] = 1'b1; tick(3);
    end
    key[0] = 1'b0;
    push(13, 0, KP); push(53, 0, KL);
    tick(12); chk("lvl_before_p", int'(key_level[0]), 0);
    tick(1);  chk("lvl_at_p", int'(key_level[0]), 1);
    tick(1);  chk("lvl_after_p", int'(key_level[0]), 1);
    chk("lvl_other", int'(key_level[1]), 0);
    tick(86);
    key[0] = 1'b1;
    push(13, 0, KR);
    tick(12); chk("lvl_before_r", int'(key_level[0]), 1);
    tick(1);  chk("lvl_at_r", int'(key_level[0]), 0);
    tick(20); chk("drain_t3", exp_q.size(), 0);

    // Auto-repeat, then repeat_en dropped mid-hold.
    repeat_en = 1'b1;
    key[0] = 1'b0;
    push(13, 0, KP); push(53, 0, KL);
    push(68, 0, KRP); push(83, 0, KRP); push(98, 0, KRP);
    tick(105);
    repeat_en = 1'b0;
    tick(35);
    key[0] = 1'b1;
    push(13, 0, KR);
    tick(30); chk("drain_t4", exp_q.size(), 0);

    // Short release glitch while held shifts the long-press by 4 cycles.
    base = cyc;
    key[0] = 1'b0;
    push(13, 0, KP); push(57, 0, KL);
    tick(20);
    key[0] = 1'b1;
    tick(4);
    key[0] = 1'b0;
    tick(1); chk("lvl_in_glitch", int'(key_level[0]), 1);
    tick(3); chk("lvl_after_glitch", int'(key_level[0]), 1);
    tick(42);
    key[0] = 1'b1;
    push(13, 0, KR);
    tick(30); chk("drain_t5", exp_q.size(), 0);
    chk("t5_len", cyc - base, 100);

    // Both keys together, then reset in the middle of the hold.
    key = 2'b00;
    push(13, 0, KP); push(13, 1, KP);
    tick(14); chk("lvl_both", int'(key_level), 3);
    tick(16);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", int'({key_level, key_p_flag, key_r_flag, key_long_flag, key_rep_flag}), 0);
    tick(2);
    key = 2'b11;
    tick(5);
    rst_n = 1'b1;
    tick(50);
    chk("post_rst_lvl", int'(key_level), 0);
    chk("drain_t6", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
